// File: rtl/pll_mdrp_ctrl.sv
`timescale 1ns/1ps
// pll_mdrp_ctrl: applies a register profile to the PLL over its MDRP port,
// verifying every write by readback and qualifying lock before reporting success.
module pll_mdrp_ctrl #(
    parameter int unsigned NREGS        = 4,
    parameter int unsigned NPROF        = 2,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned RETRIES      = 2
) (
    input  logic        mdclk,
    input  logic        reset,
    input  logic        cfg_req,
    input  logic [1:0]  cfg_profile,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err,
    output logic [5:0]  tbl_idx,
    input  logic [15:0] tbl_entry,
    output logic        pll_rst,
    input  logic        pll_lock,
    output logic        lock,
    output logic [1:0]  mdopc,
    output logic        mdainc,
    output logic [7:0]  mdwdi,
    input  logic [7:0]  mdrdo
);

    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);

    localparam logic [1:0] OPC_NOP  = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] OPC_ADDR = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_PROF = 2'd1;
    localparam logic [1:0] ERR_VFY  = 2'd2;
    localparam logic [1:0] ERR_LOCK = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_FETCH, S_SETADDR, S_WRITE, S_READ,
        S_RWAIT, S_CHECK, S_WAIT_LOCK, S_DONE, S_FAIL
    } state_t;

    state_t        state_q;
    logic [1:0]    prof_q;
    logic [3:0]    entry_q;
    logic [7:0]    attempt_q;
    logic [7:0]    data_q;
    logic [SW-1:0] stb_q, stb_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, done_q, pll_rst_q, lock_q;
    logic [1:0]    err_q, mdopc_q;
    logic [5:0]    tbl_idx_q;
    logic [7:0]    mdwdi_q;
    logic          retry_ok;

    always_comb begin
        stb_d    = pll_lock ? stb_q + SW'(1) : '0;
        tmo_d    = tmo_q + TW'(1);
        retry_ok = (attempt_q < 8'(RETRIES));
    end

    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prof_q    <= '0;
            entry_q   <= '0;
            attempt_q <= '0;
            stb_q     <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_NONE;
            pll_rst_q <= 1'b0;
            lock_q    <= 1'b0;
            mdopc_q   <= OPC_NOP;
            mdwdi_q   <= '0;
            tbl_idx_q <= '0;
        end else begin
            // Opcodes are single-cycle pulses; lock is only exposed while not reconfiguring
            done_q  <= 1'b0;
            mdopc_q <= OPC_NOP;
            lock_q  <= pll_lock & ((state_q == S_IDLE) | (state_q == S_DONE));
            case (state_q)
                S_IDLE: begin
                    if (cfg_req) begin
                        if (32'(cfg_profile) >= NPROF) begin
                            err_q <= ERR_PROF;
                        end else begin
                            prof_q    <= cfg_profile;
                            err_q     <= ERR_NONE;
                            entry_q   <= '0;
                            attempt_q <= '0;
                            tbl_idx_q <= {cfg_profile, 4'd0};
                            busy_q    <= 1'b1;
                            pll_rst_q <= 1'b1;
                            state_q   <= S_RST;
                        end
                    end
                end
                S_RST: begin
                    pll_rst_q <= 1'b1;
                    tbl_idx_q <= {prof_q, entry_q};
                    state_q   <= S_FETCH;
                end
                S_FETCH: begin
                    data_q  <= tbl_entry[7:0];
                    mdopc_q <= OPC_ADDR;
                    mdwdi_q <= tbl_entry[15:8];
                    state_q <= S_SETADDR;
                end
                S_SETADDR: begin
                    mdopc_q <= OPC_WR;
                    mdwdi_q <= data_q;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    mdopc_q <= OPC_RD;
                    state_q <= S_READ;
                end
                S_READ:  state_q <= S_RWAIT;
                S_RWAIT: state_q <= S_CHECK;
                S_CHECK: begin
                    // Readback lands here, two cycles after the read opcode
                    if (mdrdo != data_q) begin
                        if (retry_ok) begin
                            attempt_q <= attempt_q + 8'd1;
                            entry_q   <= '0;
                            tbl_idx_q <= {prof_q, 4'd0};
                            pll_rst_q <= 1'b1;
                            state_q   <= S_RST;
                        end else begin
                            err_q     <= ERR_VFY;
                            pll_rst_q <= 1'b0;
                            state_q   <= S_FAIL;
                        end
                    end else if (entry_q != 4'(NREGS - 1)) begin
                        entry_q   <= entry_q + 4'd1;
                        tbl_idx_q <= {prof_q, entry_q + 4'd1};
                        state_q   <= S_FETCH;
                    end else begin
                        pll_rst_q <= 1'b0;
                        stb_q     <= '0;
                        tmo_q     <= '0;
                        state_q   <= S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    stb_q <= stb_d;
                    tmo_q <= tmo_d;
                    if (stb_d == SW'(LOCK_STABLE)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (tmo_d == TW'(LOCK_TIMEOUT)) begin
                        if (retry_ok) begin
                            attempt_q <= attempt_q + 8'd1;
                            entry_q   <= '0;
                            tbl_idx_q <= {prof_q, 4'd0};
                            pll_rst_q <= 1'b1;
                            state_q   <= S_RST;
                        end else begin
                            err_q     <= ERR_LOCK;
                            pll_rst_q <= 1'b0;
                            state_q   <= S_FAIL;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_FAIL: begin
                    busy_q    <= 1'b0;
                    pll_rst_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tbl_idx = tbl_idx_q;
    assign pll_rst = pll_rst_q;
    assign lock    = lock_q;
    assign mdopc   = mdopc_q;
    assign mdainc  = 1'b0;
    assign mdwdi   = mdwdi_q;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
`timescale 1ns/1ps
// tb_pll_mdrp_ctrl: profile ROM, MDRP register model and PLL lock model around
// pll_mdrp_ctrl; MDRP transactions are scoreboarded against the ROM contents.
module tb_pll_mdrp_ctrl;

    logic        mdclk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_req = 1'b0;
    logic [1:0]  cfg_profile = 2'd0;
    logic        busy, done, pll_rst, lock, mdainc;
    logic [1:0]  err, mdopc;
    logic [5:0]  tbl_idx;
    logic [15:0] tbl_entry;
    logic        pll_lock;
    logic [7:0]  mdwdi;
    logic [7:0]  mdrdo;

    pll_mdrp_ctrl #(
        .NREGS(3), .NPROF(2), .LOCK_TIMEOUT(100), .LOCK_STABLE(16), .RETRIES(2)
    ) dut (
        .mdclk(mdclk), .reset(reset), .cfg_req(cfg_req), .cfg_profile(cfg_profile),
        .busy(busy), .done(done), .err(err), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
        .pll_rst(pll_rst), .pll_lock(pll_lock), .lock(lock), .mdopc(mdopc),
        .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo)
    );

    always #5 mdclk = ~mdclk;

    int n_cmp = 0;
    int n_fail = 0;

    // Profile ROM: address in the upper byte, data in the lower byte
    logic [15:0] rom [64];
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        rom[6'h00] = 16'h20A5; rom[6'h01] = 16'h215A; rom[6'h02] = 16'h220F;
        rom[6'h10] = 16'h1035; rom[6'h11] = 16'h1102; rom[6'h12] = 16'h1281;
    end
    assign tbl_entry = rom[tbl_idx];

    // MDRP register file with two-cycle read latency; bad_rd corrupts address 0x10
    logic [7:0] mem [256];
    logic [7:0] maddr = 8'h00;
    logic [7:0] rd1 = 8'h00;
    bit         bad_rd = 1'b0;
    always @(posedge mdclk) begin
        if (mdopc == 2'b11) maddr <= mdwdi;
        if (mdopc == 2'b01) mem[maddr] <= mdwdi;
        if (mdopc == 2'b10) rd1 <= (bad_rd && maddr == 8'h10) ? 8'h34 : mem[maddr];
        mdrdo <= rd1;
    end

    // PLL lock model: 0 locks 5 cycles after reset release, 1 never locks, 2 glitches once
    int lock_mode = 0;
    int lowcnt = 0;
    always @(posedge mdclk) begin
        if (pll_rst === 1'b1) lowcnt <= 0;
        else if (lowcnt < 1000) lowcnt <= lowcnt + 1;
    end
    assign pll_lock = (lock_mode == 1) ? 1'b0 :
                      (lock_mode == 2) ? (lowcnt >= 5 && lowcnt != 15) : (lowcnt >= 5);

    typedef struct { logic [1:0] opc; logic [7:0] wdi; bit chk; } txn_t;
    txn_t exp_q[$];
    txn_t obs_q[$];

    always @(negedge mdclk) begin
        if (mdopc !== 2'b00) obs_q.push_back('{opc: mdopc, wdi: mdwdi, chk: 1'b1});
    end

    typedef struct {
        int rst_fall; int nfalls; int done_at; int done_cnt;
        int err_at; int idle_at; int lock_busy; logic [1:0] err_end; logic rst_end;
    } res_t;

    task automatic push_entry(input int idx);
        logic [15:0] w;
        w = rom[idx];
        exp_q.push_back('{opc: 2'b11, wdi: w[15:8], chk: 1'b1});
        exp_q.push_back('{opc: 2'b01, wdi: w[7:0], chk: 1'b1});
        exp_q.push_back('{opc: 2'b10, wdi: 8'h00, chk: 1'b0});
    endtask

    task automatic start_req(input logic [1:0] p);
        @(negedge mdclk);
        cfg_profile = p;
        cfg_req = 1'b1;
        @(negedge mdclk);
        cfg_req = 1'b0;
    endtask

    // Called at cycle t0+1; records event cycles relative to t0 until busy drops
    task automatic run_seq(input bit poke, output res_t r);
        int cyc;
        logic prev_rst;
        r.rst_fall = -1; r.nfalls = 0; r.done_at = -1; r.done_cnt = 0;
        r.err_at = -1; r.idle_at = -1; r.lock_busy = 0;
        cyc = 1;
        prev_rst = pll_rst;
        while (cyc < 600) begin
            if (prev_rst && !pll_rst) begin
                r.nfalls++;
                if (r.rst_fall < 0) r.rst_fall = cyc;
            end
            prev_rst = pll_rst;
            if (done) begin
                r.done_cnt++;
                if (r.done_at < 0) r.done_at = cyc;
            end
            if (err != 2'd0 && r.err_at < 0) r.err_at = cyc;
            if (busy && lock && cyc >= 2) r.lock_busy++;
            if (!busy) begin
                r.idle_at = cyc;
                break;
            end
            if (poke) begin
                cfg_profile = 2'd1;
                cfg_req = (mdopc == 2'b01);
            end
            @(negedge mdclk);
            cyc++;
        end
        cfg_req = 1'b0;
        r.err_end = err;
        r.rst_end = pll_rst;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge mdclk);
        n_cmp++; if ({busy, done, err, pll_rst, lock} !== 6'd0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b, required 000000", {busy, done, err, pll_rst, lock}); end
        n_cmp++; if ({mdopc, mdainc, mdwdi} !== 11'd0) begin n_fail++;
            $display("FAIL reset_mdrp: got %h, required 000", {mdopc, mdainc, mdwdi}); end
        n_cmp++; if (tbl_idx !== 6'd0) begin n_fail++;
            $display("FAIL reset_tbl_idx: got %h, required 00", tbl_idx); end
        reset = 1'b0;
        repeat (10) @(negedge mdclk);
        n_cmp++; if (lock !== 1'b1) begin n_fail++;
            $display("FAIL idle_lock_follow: got %b, required 1", lock); end
    endtask

    task automatic test_success();
        res_t r;
        txn_t e, o;
        for (int i = 0; i < 3; i++) push_entry(6'h10 + i);
        start_req(2'd1);
        n_cmp++; if ({busy, pll_rst} !== 2'b11) begin n_fail++;
            $display("FAIL ok_t1_busy_rst: got %b, required 11", {busy, pll_rst}); end
        n_cmp++; if (tbl_idx !== 6'h10) begin n_fail++;
            $display("FAIL ok_tbl_idx: got %h, required 10", tbl_idx); end
        run_seq(1'b0, r);
        n_cmp++; if (r.rst_fall != 20) begin n_fail++;
            $display("FAIL ok_rst_fall: got t0+%0d, required t0+20", r.rst_fall); end
        n_cmp++; if (r.done_at != 41 || r.done_cnt != 1) begin n_fail++;
            $display("FAIL ok_done: got t0+%0d x%0d, required t0+41 x1", r.done_at, r.done_cnt); end
        n_cmp++; if (r.idle_at != 42 || r.err_end !== 2'd0) begin n_fail++;
            $display("FAIL ok_end: got idle t0+%0d err %0d, required t0+42 err 0", r.idle_at, r.err_end); end
        n_cmp++; if (r.lock_busy != 0 || lock !== 1'b1) begin n_fail++;
            $display("FAIL ok_lock: got %0d busy-lock cycles, lock %b, required 0, 1", r.lock_busy, lock); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_fail++;
                $display("FAIL ok_txn: got %b/%h, required none", o.opc, o.wdi);
            end else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_fail++;
                $display("FAIL ok_txn: got none, required %b/%h", e.opc, e.wdi);
            end else begin e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.opc !== e.opc || (e.chk && o.wdi !== e.wdi)) begin n_fail++;
                    $display("FAIL ok_txn: got %b/%h, required %b/%h", o.opc, o.wdi, e.opc, e.wdi); end
            end
        end
    endtask

    task automatic test_bad_profile();
        int act;
        start_req(2'd2);
        n_cmp++; if ({err, busy} !== 3'b010) begin n_fail++;
            $display("FAIL bad2: got err %0d busy %b, required err 1 busy 0", err, busy); end
        start_req(2'd3);
        n_cmp++; if ({err, busy} !== 3'b010) begin n_fail++;
            $display("FAIL bad3: got err %0d busy %b, required err 1 busy 0", err, busy); end
        act = 0;
        repeat (4) begin
            @(negedge mdclk);
            if (busy || pll_rst || mdopc != 2'b00) act++;
        end
        n_cmp++; if (act != 0 || obs_q.size() != 0) begin n_fail++;
            $display("FAIL bad_quiet: got %0d active cycles %0d txns, required 0 0", act, obs_q.size()); end
    endtask

    task automatic test_verify_mismatch();
        res_t r;
        txn_t e, o;
        bad_rd = 1'b1;
        repeat (3) push_entry(6'h10);
        start_req(2'd1);
        n_cmp++; if (err !== 2'd0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL vfy_accept: got err %0d busy %b, required err 0 busy 1", err, busy); end
        run_seq(1'b0, r);
        n_cmp++; if (r.err_at != 22 || r.err_end !== 2'd2) begin n_fail++;
            $display("FAIL vfy_err: got %0d at t0+%0d, required 2 at t0+22", r.err_end, r.err_at); end
        n_cmp++; if (r.done_cnt != 0 || r.rst_fall != 22 || r.rst_end !== 1'b0) begin n_fail++;
            $display("FAIL vfy_end: got done x%0d rst fall t0+%0d rst %b, required x0 t0+22 0",
                     r.done_cnt, r.rst_fall, r.rst_end); end
        n_cmp++; if (r.idle_at != 23) begin n_fail++;
            $display("FAIL vfy_idle: got t0+%0d, required t0+23", r.idle_at); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_fail++;
                $display("FAIL vfy_txn: got %b/%h, required none", o.opc, o.wdi);
            end else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_fail++;
                $display("FAIL vfy_txn: got none, required %b/%h", e.opc, e.wdi);
            end else begin e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.opc !== e.opc || (e.chk && o.wdi !== e.wdi)) begin n_fail++;
                    $display("FAIL vfy_txn: got %b/%h, required %b/%h", o.opc, o.wdi, e.opc, e.wdi); end
            end
        end
        bad_rd = 1'b0;
    endtask

    task automatic test_lock_timeout();
        res_t r;
        txn_t e, o;
        lock_mode = 1;
        repeat (3) for (int i = 0; i < 3; i++) push_entry(6'h10 + i);
        start_req(2'd1);
        run_seq(1'b0, r);
        n_cmp++; if (r.err_at != 358 || r.err_end !== 2'd3) begin n_fail++;
            $display("FAIL tmo_err: got %0d at t0+%0d, required 3 at t0+358", r.err_end, r.err_at); end
        n_cmp++; if (r.nfalls != 3 || r.rst_fall != 20) begin n_fail++;
            $display("FAIL tmo_passes: got %0d rst falls first t0+%0d, required 3 first t0+20", r.nfalls, r.rst_fall); end
        n_cmp++; if (r.done_cnt != 0 || r.idle_at != 359 || lock !== 1'b0) begin n_fail++;
            $display("FAIL tmo_end: got done x%0d idle t0+%0d lock %b, required x0 t0+359 0",
                     r.done_cnt, r.idle_at, lock); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_fail++;
                $display("FAIL tmo_txn: got %b/%h, required none", o.opc, o.wdi);
            end else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_fail++;
                $display("FAIL tmo_txn: got none, required %b/%h", e.opc, e.wdi);
            end else begin e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.opc !== e.opc || (e.chk && o.wdi !== e.wdi)) begin n_fail++;
                    $display("FAIL tmo_txn: got %b/%h, required %b/%h", o.opc, o.wdi, e.opc, e.wdi); end
            end
        end
        lock_mode = 0;
    endtask

    task automatic test_lock_glitch();
        res_t r;
        txn_t e, o;
        lock_mode = 2;
        for (int i = 0; i < 3; i++) push_entry(i);
        start_req(2'd0);
        run_seq(1'b0, r);
        n_cmp++; if (r.done_at != 52 || r.done_cnt != 1) begin n_fail++;
            $display("FAIL glitch_done: got t0+%0d x%0d, required t0+52 x1", r.done_at, r.done_cnt); end
        n_cmp++; if (r.err_end !== 2'd0 || r.idle_at != 53) begin n_fail++;
            $display("FAIL glitch_end: got err %0d idle t0+%0d, required 0 t0+53", r.err_end, r.idle_at); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_fail++;
                $display("FAIL glitch_txn: got %b/%h, required none", o.opc, o.wdi);
            end else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_fail++;
                $display("FAIL glitch_txn: got none, required %b/%h", e.opc, e.wdi);
            end else begin e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.opc !== e.opc || (e.chk && o.wdi !== e.wdi)) begin n_fail++;
                    $display("FAIL glitch_txn: got %b/%h, required %b/%h", o.opc, o.wdi, e.opc, e.wdi); end
            end
        end
        lock_mode = 0;
    endtask

    task automatic test_ignored_req();
        res_t r;
        txn_t e, o;
        int act;
        for (int i = 0; i < 3; i++) push_entry(i);
        start_req(2'd0);
        run_seq(1'b1, r);
        n_cmp++; if (r.done_at != 41 || r.done_cnt != 1 || r.idle_at != 42) begin n_fail++;
            $display("FAIL ign_done: got t0+%0d x%0d idle t0+%0d, required t0+41 x1 t0+42",
                     r.done_at, r.done_cnt, r.idle_at); end
        act = 0;
        repeat (5) begin
            @(negedge mdclk);
            if (busy || pll_rst) act++;
        end
        n_cmp++; if (act != 0) begin n_fail++;
            $display("FAIL ign_not_queued: got %0d busy cycles, required 0", act); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_fail++;
                $display("FAIL ign_txn: got %b/%h, required none", o.opc, o.wdi);
            end else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_fail++;
                $display("FAIL ign_txn: got none, required %b/%h", e.opc, e.wdi);
            end else begin e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.opc !== e.opc || (e.chk && o.wdi !== e.wdi)) begin n_fail++;
                    $display("FAIL ign_txn: got %b/%h, required %b/%h", o.opc, o.wdi, e.opc, e.wdi); end
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t r;
        txn_t e, o;
        int wcnt, cyc;
        push_entry(6'h10);
        exp_q.push_back('{opc: 2'b11, wdi: 8'h11, chk: 1'b1});
        exp_q.push_back('{opc: 2'b01, wdi: 8'h02, chk: 1'b1});
        start_req(2'd1);
        wcnt = 0;
        cyc = 0;
        while (cyc < 40) begin
            if (mdopc == 2'b01) wcnt++;
            if (wcnt == 2) break;
            @(negedge mdclk);
            cyc++;
        end
        n_cmp++; if (wcnt != 2) begin n_fail++;
            $display("FAIL mid_second_write: got %0d writes in 40 cycles, required 2", wcnt); end
        reset = 1'b1;
        @(negedge mdclk);
        n_cmp++; if ({busy, done, err, pll_rst, lock} !== 6'd0) begin n_fail++;
            $display("FAIL mid_ctrl: got %b, required 000000", {busy, done, err, pll_rst, lock}); end
        n_cmp++; if ({mdopc, mdainc, mdwdi, tbl_idx} !== 17'd0) begin n_fail++;
            $display("FAIL mid_outputs: got %h, required 00000", {mdopc, mdainc, mdwdi, tbl_idx}); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) push_entry(i);
        start_req(2'd0);
        n_cmp++; if ({busy, pll_rst} !== 2'b11) begin n_fail++;
            $display("FAIL mid_restart: got %b, required 11", {busy, pll_rst}); end
        run_seq(1'b0, r);
        n_cmp++; if (r.done_at != 41 || r.err_end !== 2'd0) begin n_fail++;
            $display("FAIL mid_done: got t0+%0d err %0d, required t0+41 err 0", r.done_at, r.err_end); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin o = obs_q.pop_front(); n_fail++;
                $display("FAIL mid_txn: got %b/%h, required none", o.opc, o.wdi);
            end else if (obs_q.size() == 0) begin e = exp_q.pop_front(); n_fail++;
                $display("FAIL mid_txn: got none, required %b/%h", e.opc, e.wdi);
            end else begin e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.opc !== e.opc || (e.chk && o.wdi !== e.wdi)) begin n_fail++;
                    $display("FAIL mid_txn: got %b/%h, required %b/%h", o.opc, o.wdi, e.opc, e.wdi); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 ns, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_success();
        test_bad_profile();
        test_verify_mismatch();
        test_lock_timeout();
        test_lock_glitch();
        test_ignored_req();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
